// File: rtl/rng_range_sampler_if.sv
// Request/result bundle between a client and rng_range_sampler.
`timescale 1ns/1ps
interface rng_range_sampler_if #(
  parameter int WIDTH = 16,
  parameter int TRY_W = 4
);
  logic             start;
  logic [WIDTH-1:0] bound;
  logic             ready;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             fallback;
  logic             err;
  logic [TRY_W-1:0] tries;

  modport master (
    output start, bound,
    input  ready, value, valid, fallback, err, tries
  );

  modport slave (
    input  start, bound,
    output ready, value, valid, fallback, err, tries
  );
endinterface

// File: rtl/rng_range_sampler.sv
// Mask-and-reject sampler: turns raw LFSR draws into uniform values in [0, bound).
// After MAX_TRIES rejected draws the last candidate is folded once by subtraction.
`timescale 1ns/1ps
module rng_range_sampler #(
  parameter int WIDTH     = 16,
  parameter int MAX_TRIES = 8,
  parameter int TRY_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  rng_range_sampler_if.slave io_req,
  output logic               o_rng_req,
  input  logic [WIDTH-1:0]   i_rng_data,
  input  logic               i_rng_done
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t           r_state,    w_state_nxt;
  logic [WIDTH-1:0] r_bound,    w_bound_nxt;
  logic [WIDTH-1:0] r_mask,     w_mask_nxt;
  logic [WIDTH-1:0] r_value,    w_value_nxt;
  logic [TRY_W-1:0] r_tries,    w_tries_nxt;
  logic             r_fallback, w_fallback_nxt;
  logic             r_err,      w_err_nxt;
  logic             r_first,    w_first_nxt;
  logic [WIDTH-1:0] w_cand;

  // Smallest 2^k-1 covering x.
  function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = x;
    for (int s = 1; s < WIDTH; s = s * 2) y = y | (y >> s);
    return y;
  endfunction

  assign w_cand = i_rng_data & r_mask;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_bound    <= '0;
      r_mask     <= '0;
      r_value    <= '0;
      r_tries    <= '0;
      r_fallback <= 1'b0;
      r_err      <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bound    <= w_bound_nxt;
      r_mask     <= w_mask_nxt;
      r_value    <= w_value_nxt;
      r_tries    <= w_tries_nxt;
      r_fallback <= w_fallback_nxt;
      r_err      <= w_err_nxt;
      r_first    <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bound_nxt    = r_bound;
    w_mask_nxt     = r_mask;
    w_value_nxt    = r_value;
    w_tries_nxt    = r_tries;
    w_fallback_nxt = r_fallback;
    w_err_nxt      = r_err;
    w_first_nxt    = r_first;
    case (r_state)
      S_IDLE: begin
        if (io_req.start) begin
          w_bound_nxt    = io_req.bound;
          w_mask_nxt     = smear(io_req.bound - WIDTH'(1));
          w_tries_nxt    = '0;
          w_fallback_nxt = 1'b0;
          w_err_nxt      = 1'b0;
          if (io_req.bound == '0) begin
            w_value_nxt = '0;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_tries_nxt = r_tries + TRY_W'(1);
        w_first_nxt = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // done may still be high from the previous draw during the first cycle
        w_first_nxt = 1'b0;
        if (!r_first && i_rng_done) begin
          if (w_cand < r_bound) begin
            w_value_nxt = w_cand;
            w_state_nxt = S_DONE;
          end else if (r_tries < TRY_W'(MAX_TRIES)) begin
            w_state_nxt = S_REQ;
          end else begin
            // mask < 2*bound, so a single subtraction lands in range
            w_value_nxt    = w_cand - r_bound;
            w_fallback_nxt = 1'b1;
            w_state_nxt    = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign io_req.ready    = (r_state == S_IDLE);
  assign io_req.valid    = (r_state == S_DONE);
  assign io_req.value    = r_value;
  assign io_req.fallback = r_fallback;
  assign io_req.err      = r_err;
  assign io_req.tries    = r_tries;
  assign o_rng_req       = (r_state == S_REQ);

endmodule

// File: tb/tb_rng_range_sampler.sv
// Bench for rng_range_sampler: shared LFSR model feeding two instances
// (MAX_TRIES=8 and MAX_TRIES=1), scoreboard of expected results.
`timescale 1ns/1ps
module tb_rng_range_sampler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rng_range_sampler_if #(.WIDTH(16), .TRY_W(4)) if0 ();
  rng_range_sampler_if #(.WIDTH(16), .TRY_W(4)) if1 ();

  logic        req0, req1;
  logic        lfsr_done;
  logic [15:0] lfsr_data;

  rng_range_sampler #(.WIDTH(16), .MAX_TRIES(8), .TRY_W(4)) dut0 (
    .i_clk(clk), .i_rst(rst), .io_req(if0), .o_rng_req(req0),
    .i_rng_data(lfsr_data), .i_rng_done(lfsr_done));

  rng_range_sampler #(.WIDTH(16), .MAX_TRIES(1), .TRY_W(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .io_req(if1), .o_rng_req(req1),
    .i_rng_data(lfsr_data), .i_rng_done(lfsr_done));

  // LFSR model (seed 5): en sampled on an edge clears done, done rises two edges later.
  logic [15:0] draws [8];
  int          d_idx;
  logic [1:0]  d_cnt;
  initial begin
    draws[0] = 16'h000B; draws[1] = 16'h0016; draws[2] = 16'h002D; draws[3] = 16'h005A;
    draws[4] = 16'h00B5; draws[5] = 16'h016A; draws[6] = 16'h02D5; draws[7] = 16'h05AB;
  end
  always @(posedge clk) begin
    if (rst) begin
      d_idx <= 0; d_cnt <= 2'd0; lfsr_done <= 1'b0; lfsr_data <= 16'h0;
    end else if (req0 || req1) begin
      lfsr_done <= 1'b0; d_cnt <= 2'd2;
    end else if (d_cnt != 2'd0) begin
      d_cnt <= d_cnt - 2'd1;
      if (d_cnt == 2'd1) begin
        lfsr_done <= 1'b1;
        lfsr_data <= draws[d_idx[2:0]];
        d_idx     <= d_idx + 1;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int          dut;
    logic [15:0] value;
    int          tries;
    bit          fb;
    bit          err;
  } exp_t;
  exp_t sb[$];

  int req_cnt = 0;
  int acc0 = 0;
  always @(negedge clk) begin
    int   d;
    exp_t e;
    if (!rst && (req0 || req1)) req_cnt++;
    if (!rst && if0.start && if0.ready) acc0++;
    if (!rst && (if0.valid || if1.valid)) begin
      d = if1.valid ? 1 : 0;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_dut",      d, e.dut);
        chk("sb_value",    d ? int'(if1.value)    : int'(if0.value),    int'(e.value));
        chk("sb_tries",    d ? int'(if1.tries)    : int'(if0.tries),    e.tries);
        chk("sb_fallback", d ? int'(if1.fallback) : int'(if0.fallback), int'(e.fb));
        chk("sb_err",      d ? int'(if1.err)      : int'(if0.err),      int'(e.err));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if0.start = 1'b0; if1.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_req(input int dut, input logic [15:0] b, input logic [15:0] v,
                         input int t, input bit fb, input bit er);
    int   lat;
    bit   got;
    logic vld, rdy;
    sb.push_back('{dut, v, t, fb, er});
    @(negedge clk);
    if (dut == 0) begin if0.start = 1'b1; if0.bound = b; end
    else          begin if1.start = 1'b1; if1.bound = b; end
    req_cnt = 0;
    @(posedge clk);
    #1;
    // bound changes after acceptance must not matter
    if (dut == 0) begin if0.start = 1'b0; if0.bound = ~b; end
    else          begin if1.start = 1'b0; if1.bound = ~b; end
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      vld = (dut == 0) ? if0.valid : if1.valid;
      rdy = (dut == 0) ? if0.ready : if1.ready;
      if (c == 0) chk("busy_ready", int'(rdy), 0);
      if (vld) begin got = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    chk("valid_seen", int'(got), 1);
    chk("latency", lat, 4 * t);
    chk("rng_req_pulses", req_cnt, t);
  endtask

  typedef struct {
    bit          rst_first;
    int          dut;
    logic [15:0] bound;
    logic [15:0] value;
    int          tries;
    bit          fb;
    bit          err;
  } vec_t;
  vec_t vecs[12];

  int nv;
  logic [15:0] held_vals [4];

  initial begin
    vecs[0]  = '{1'b1, 0, 16'd10,    16'd6,  2, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 0, 16'd1,     16'd0,  1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 0, 16'hFFFF,  16'd11, 1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 0, 16'd0,     16'd0,  0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 0, 16'd5,     16'd2,  3, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 0, 16'd11,    16'd6,  2, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 0, 16'd3,     16'd2,  2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 0, 16'd2,     16'd1,  1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1, 16'd10,    16'd1,  1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1, 16'd0,     16'd0,  0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1, 16'd3,     16'd0,  1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1, 16'd7,     16'd3,  1, 1'b0, 1'b0};
    held_vals[0] = 16'd11; held_vals[1] = 16'd22; held_vals[2] = 16'd45; held_vals[3] = 16'd26;

    if0.start = 1'b0; if0.bound = 16'h0;
    if1.start = 1'b0; if1.bound = 16'h0;

    do_reset();
    chk("rst_ready",    int'(if0.ready),    1);
    chk("rst_valid",    int'(if0.valid),    0);
    chk("rst_value",    int'(if0.value),    0);
    chk("rst_tries",    int'(if0.tries),    0);
    chk("rst_fallback", int'(if0.fallback), 0);
    chk("rst_err",      int'(if0.err),      0);
    chk("rst_rng_req",  int'(req0),         0);
    chk("rst_ready1",   int'(if1.ready),    1);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      run_req(vecs[i].dut, vecs[i].bound, vecs[i].value, vecs[i].tries, vecs[i].fb, vecs[i].err);
    end

    // reset while waiting on a draw
    do_reset();
    @(negedge clk);
    if0.start = 1'b1; if0.bound = 16'd10;
    @(posedge clk);
    #1 if0.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_tries", int'(if0.tries), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready",   int'(if0.ready), 1);
    chk("midrst_rng_req", int'(req0),      0);
    chk("midrst_valid",   int'(if0.valid), 0);
    chk("midrst_tries",   int'(if0.tries), 0);
    rst = 1'b0;
    run_req(0, 16'd64, 16'd11, 1, 1'b0, 1'b0);

    // start held high: one request per IDLE visit
    do_reset();
    foreach (held_vals[i]) sb.push_back('{0, held_vals[i], 1, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    acc0 = 0;
    if0.start = 1'b1; if0.bound = 16'd64;
    nv = 0;
    for (int c = 0; c < 400 && nv < 4; c++) begin
      @(negedge clk);
      if (if0.valid) nv++;
    end
    if0.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("held_valids",  nv,   4);
    chk("held_accepts", acc0, 4);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
